// File: rtl/mdu_param_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
// The pipeline side uses the master modport, the MDU uses the slave modport.
interface mdu_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_param.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, multiply-accumulate
// and configurable per-class latency. Results are computed at accept and released after N cycles.
module mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_param_if.slave   bus
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_hi, w_hi_next;
  logic [WIDTH-1:0] r_lo, w_lo_next;
  logic [WIDTH-1:0] r_res_hi, w_res_hi_next;
  logic [WIDTH-1:0] r_res_lo, w_res_lo_next;
  logic             r_done, w_done_next;

  logic             w_is_md;
  logic             w_is_div;
  logic [2*WIDTH-1:0] w_rs_sx, w_rt_sx, w_rs_zx, w_rt_zx;
  logic [2*WIDTH-1:0] w_sprod, w_uprod, w_acc, w_mul_res;
  logic signed [WIDTH-1:0] w_a_s, w_b_s, w_sq, w_sr;
  logic [WIDTH-1:0] w_uq, w_ur;
  logic [WIDTH-1:0] w_min_neg;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;

  assign w_is_md  = (bus.op >= 4'd1) && (bus.op <= 4'd8);
  assign w_is_div = (bus.op == 4'd3) || (bus.op == 4'd4);

  // Operands widened to 2*WIDTH so the product wraps modulo 2^(2*WIDTH).
  assign w_rs_sx = {{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data};
  assign w_rt_sx = {{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data};
  assign w_rs_zx = {{WIDTH{1'b0}}, bus.rs_data};
  assign w_rt_zx = {{WIDTH{1'b0}}, bus.rt_data};
  assign w_sprod = w_rs_sx * w_rt_sx;
  assign w_uprod = w_rs_zx * w_rt_zx;
  assign w_acc   = {r_hi, r_lo};

  assign w_a_s     = $signed(bus.rs_data);
  assign w_b_s     = $signed(bus.rt_data);
  assign w_sq      = w_a_s / w_b_s;
  assign w_sr      = w_a_s % w_b_s;
  assign w_uq      = bus.rs_data / bus.rt_data;
  assign w_ur      = bus.rs_data % bus.rt_data;
  assign w_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    w_mul_res = w_sprod;
    case (bus.op)
      4'd2:    w_mul_res = w_uprod;
      4'd5:    w_mul_res = w_acc + w_sprod;
      4'd6:    w_mul_res = w_acc + w_uprod;
      4'd7:    w_mul_res = w_acc - w_sprod;
      4'd8:    w_mul_res = w_acc - w_uprod;
      default: w_mul_res = w_sprod;
    endcase
  end

  // Zero divisor and the single signed-overflow case bypass the divider.
  always_comb begin
    w_div_hi = w_ur;
    w_div_lo = w_uq;
    if (bus.rt_data == '0) begin
      w_div_hi = bus.rs_data;
      w_div_lo = '1;
    end else if (bus.op == 4'd3) begin
      if ((bus.rs_data == w_min_neg) && (bus.rt_data == '1)) begin
        w_div_hi = '0;
        w_div_lo = w_min_neg;
      end else begin
        w_div_hi = w_sr;
        w_div_lo = w_sq;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_hi_next     = r_hi;
    w_lo_next     = r_lo;
    w_res_hi_next = r_res_hi;
    w_res_lo_next = r_res_lo;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_is_md) begin
            w_state_next = ST_RUN;
            if (w_is_div) begin
              w_cnt_next    = CW'(DIV_CYCLES);
              w_res_hi_next = w_div_hi;
              w_res_lo_next = w_div_lo;
            end else begin
              w_cnt_next    = CW'(MUL_CYCLES);
              w_res_hi_next = w_mul_res[2*WIDTH-1:WIDTH];
              w_res_lo_next = w_mul_res[WIDTH-1:0];
            end
          end else if (bus.op == 4'd9) begin
            w_hi_next = bus.rs_data;
          end else if (bus.op == 4'd10) begin
            w_lo_next = bus.rs_data;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt > CW'(1)) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_cnt_next   = '0;
          w_hi_next    = r_res_hi;
          w_lo_next    = r_res_lo;
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_res_hi <= w_res_hi_next;
      r_res_lo <= w_res_lo_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.stall_req = bus.busy | (bus.start & w_is_md);
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_mdu_param;

  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mdu_param_if #(.WIDTH(W)) bus ();

  mdu_param #(.WIDTH(W), .MUL_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one multi-cycle op, check busy/done over its life; returns in the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    #1;
    check({tag, " stall_at_issue"}, 64'(bus.stall_req), 64'd1);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({tag, " busy"}, 64'({bus.busy, bus.done, bus.stall_req}), 64'b101);
      tick();
    end
    check({tag, " busy_fall_done"}, 64'({bus.busy, bus.done}), 64'b01);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    $display("[TB] %s op=%0d rs=%h rt=%h -> hi=%h lo=%h", tag, op, a, b, bus.hi, bus.lo);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 4'd0;
    bus.rs_data = '0;
    bus.rt_data = '0;

    // Reset held for two cycles
    tick();
    tick();
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy_done", 64'({bus.busy, bus.done}), 64'b00);
    check("reset stall", 64'(bus.stall_req), 64'd0);
    bus.start = 1'b1;
    bus.op    = 4'd3;
    #1;
    check("stall div start", 64'(bus.stall_req), 64'd1);
    bus.op = 4'd9;
    #1;
    check("stall mthi start", 64'(bus.stall_req), 64'd0);
    bus.op = 4'd12;
    #1;
    check("stall op12 start", 64'(bus.stall_req), 64'd0);
    bus.start = 1'b0;
    bus.op    = 4'd0;
    tick();
    reset = 1'b1;
    tick();
    check("idle after reset", 64'({bus.busy, bus.done, bus.hi, bus.lo}), 64'd0);
    $display("[TB] reset hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

    // Multiply and accumulate chain, each issued in the previous done cycle
    run_op("mult",  4'd1, 32'hFFFFFFFF, 32'h00000002, NM, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, NM, 32'hFFFFFFFE, 32'h00000001);
    run_op("madd",  4'd5, 32'd3,        32'hFFFFFFFF, NM, 32'hFFFFFFFD, 32'hFFFFFFFE);
    run_op("msubu", 4'd8, 32'd2,        32'd3,        NM, 32'hFFFFFFFD, 32'hFFFFFFF8);
    run_op("msub",  4'd7, 32'd2,        32'hFFFFFFFD, NM, 32'hFFFFFFFD, 32'hFFFFFFFE);
    run_op("maddu", 4'd6, 32'd1,        32'd1,        NM, 32'hFFFFFFFD, 32'hFFFFFFFF);
    tick();
    check("done one pulse", 64'(bus.done), 64'd0);

    // Divides
    run_op("div -7/2",   4'd3, 32'hFFFFFFF9, 32'd2,        ND, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu 7/0",   4'd4, 32'd7,        32'd0,        ND, 32'h00000007, 32'hFFFFFFFF);
    run_op("div ovf",    4'd3, 32'h80000000, 32'hFFFFFFFF, ND, 32'h00000000, 32'h80000000);
    run_op("div 7/-2",   4'd3, 32'd7,        32'hFFFFFFFE, ND, 32'h00000001, 32'hFFFFFFFD);
    run_op("div 5/0",    4'd3, 32'd5,        32'd0,        ND, 32'h00000005, 32'hFFFFFFFF);
    run_op("divu 100/7", 4'd4, 32'd100,      32'd7,        ND, 32'h00000002, 32'h0000000E);
    tick();

    // mthi / mtlo: single-edge update, no busy phase
    bus.start   = 1'b1;
    bus.op      = 4'd9;
    bus.rs_data = 32'h1234;
    tick();
    bus.start = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi lo kept", 64'(bus.lo), 64'h0000000E);
    check("mthi busy_done", 64'({bus.busy, bus.done}), 64'b00);
    $display("[TB] mthi rs=%h -> hi=%h busy=%b", 32'h1234, bus.hi, bus.busy);
    bus.start   = 1'b1;
    bus.op      = 4'd10;
    bus.rs_data = 32'hAA;
    tick();
    bus.start = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'hAA);
    check("mtlo hi kept", 64'(bus.hi), 64'h1234);
    tick();
    check("mtlo no busy", 64'({bus.busy, bus.done}), 64'b00);
    $display("[TB] mtlo rs=%h -> lo=%h", 32'hAA, bus.lo);

    // mult 6*7 with an mtlo issued in busy cycle 2, which must be ignored
    bus.start   = 1'b1;
    bus.op      = 4'd1;
    bus.rs_data = 32'd6;
    bus.rt_data = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start   = 1'b1;
    bus.op      = 4'd10;
    bus.rs_data = 32'h55;
    tick();
    bus.start = 1'b0;
    check("ignored mtlo lo", 64'(bus.lo), 64'hAA);
    check("ignored mtlo busy", 64'(bus.busy), 64'd1);
    tick();
    tick();
    tick();
    check("mult6x7 done", 64'({bus.busy, bus.done}), 64'b01);
    check("mult6x7 hi", 64'(bus.hi), 64'd0);
    check("mult6x7 lo", 64'(bus.lo), 64'd42);
    $display("[TB] mult 6x7 with ignored mtlo -> hi=%h lo=%h", bus.hi, bus.lo);
    tick();

    // Reset in busy cycle 4 of a divide
    bus.start   = 1'b1;
    bus.op      = 4'd3;
    bus.rs_data = 32'd100;
    bus.rt_data = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid-reset busy_done", 64'({bus.busy, bus.done}), 64'b00);
    check("mid-reset hi", 64'(bus.hi), 64'd0);
    check("mid-reset lo", 64'(bus.lo), 64'd0);
    for (int k = 0; k < ND + 2; k++) begin
      tick();
      check("no done after reset", 64'({bus.busy, bus.done, bus.hi, bus.lo}), 64'd0);
    end
    $display("[TB] reset mid-div -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
